// File: rtl/ram_lane_scheduler_if.sv
// ram_lane_scheduler_if: bundle of the three requester lanes and the shared 3-lane RAM port
// Lane side: lane_req/lane_we/lane_addr/lane_wdata in, lane_rdata/lane_ack out (lane i at slice i).
// RAM side: mem_read/mem_write/mem_address/mem_data_in out, mem_data_out in.
// slave = the scheduler, master = the requesters plus the RAM.
interface ram_lane_scheduler_if #(parameter int DATA_LEN = 16, parameter int ADDRESS_LEN = 8);
  logic [2:0] lane_req, lane_we, lane_ack;
  logic [3*ADDRESS_LEN-1:0] lane_addr, mem_address;
  logic [3*DATA_LEN-1:0] lane_wdata, lane_rdata, mem_data_in, mem_data_out;
  logic mem_read, mem_write;
  modport master (output lane_req, lane_we, lane_addr, lane_wdata, mem_data_out,
                  input lane_rdata, lane_ack, mem_read, mem_write, mem_address, mem_data_in);
  modport slave (input lane_req, lane_we, lane_addr, lane_wdata, mem_data_out,
                 output lane_rdata, lane_ack, mem_read, mem_write, mem_address, mem_data_in);
endinterface

// File: rtl/ram_lane_scheduler.sv
// ram_lane_scheduler: batches read/write requests of three lanes into single shared-RAM cycles
// Ports: clk, reset (sync, active high), bus (ram_lane_scheduler_if.slave: lane handshake + RAM port).
// Optional RAM_SCHED_SERIALIZE_EN: same-address writes are split into successive write batches in lane order.
module ram_lane_scheduler #(parameter int DATA_LEN = 16, parameter int ADDRESS_LEN = 8) (
  input logic clk,
  input logic reset,
  ram_lane_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DONE, WR_ISSUE} state_t;
  state_t state_q, state_d;
  logic [2:0] pend_q, pend_d, we_q, we_d, grant_q, grant_d, ack_q, ack_d;
  logic [2:0][ADDRESS_LEN-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d, lane_addr, addr_all;
  logic [2:0][DATA_LEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d, mem_din_q, mem_din_d;
  logic [2:0][DATA_LEN-1:0] lane_wdata, mem_dout, wdata_all;
  logic last_wr_q, last_wr_d, force_wr_q, force_wr_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d, pick_wr;
  logic [2:0] new_l, we_all, rd_l, wr_l, wr_g, gmask;
  logic [1:0] lo;
  assign lane_addr = bus.lane_addr;
  assign lane_wdata = bus.lane_wdata;
  assign mem_dout = bus.mem_data_out;
  assign bus.lane_rdata = rdata_q;
  assign bus.lane_ack = ack_q;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_address = mem_addr_q;
  assign bus.mem_data_in = mem_din_q;
  // last_wr: the next read/write tie goes to writes; it flips only on such ties.
  // force_wr: a write batch left colliding writes behind, so the next batch is writes again.
  always_comb begin
    new_l = bus.lane_req & ~pend_q & ~ack_q;
    for (int i = 0; i < 3; i++) begin
      we_all[i] = new_l[i] ? bus.lane_we[i] : we_q[i];
      addr_all[i] = new_l[i] ? lane_addr[i] : addr_q[i];
      wdata_all[i] = new_l[i] ? lane_wdata[i] : wdata_q[i];
    end
    rd_l = (pend_q | new_l) & ~we_all;
    wr_l = (pend_q | new_l) & we_all;
    wr_g = wr_l;
`ifdef RAM_SCHED_SERIALIZE_EN
    for (int i = 1; i < 3; i++)
      for (int j = 0; j < i; j++)
        if (wr_l[j] && addr_all[j] == addr_all[i]) wr_g[i] = 1'b0;
`endif
    pick_wr = |wr_l && (~|rd_l || last_wr_q || force_wr_q);
    gmask = pick_wr ? wr_g : rd_l;
    lo = gmask[0] ? 2'd0 : gmask[1] ? 2'd1 : 2'd2;
    state_d = state_q;
    pend_d = pend_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    last_wr_d = last_wr_q;
    force_wr_d = force_wr_q;
    mem_read_d = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    ack_d = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        pend_d = pend_q | new_l;
        we_d = we_all;
        addr_d = addr_all;
        wdata_d = wdata_all;
        if (|(rd_l | wr_l)) begin
          state_d = pick_wr ? WR_ISSUE : RD_ISSUE;
          mem_write_d = pick_wr;
          mem_read_d = !pick_wr;
          grant_d = gmask;
          force_wr_d = pick_wr && |(wr_l & ~wr_g);
          last_wr_d = (|rd_l && |wr_l && !force_wr_q) ? !pick_wr : last_wr_q;
          // idle RAM lanes mirror the lowest granted lane so they cannot disturb memory
          for (int i = 0; i < 3; i++) begin
            mem_addr_d[i] = gmask[i] ? addr_all[i] : addr_all[lo];
            mem_din_d[i] = gmask[i] ? wdata_all[i] : wdata_all[lo];
          end
        end
      end
      RD_ISSUE: state_d = RD_DONE;
      RD_DONE: begin
        for (int i = 0; i < 3; i++)
          if (grant_q[i]) rdata_d[i] = mem_dout[i];
        ack_d = grant_q;
        pend_d = pend_q & ~grant_q;
        state_d = IDLE;
      end
      default: begin
        ack_d = grant_q;
        pend_d = pend_q & ~grant_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q <= '0;
      we_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      grant_q <= '0;
      last_wr_q <= 1'b0;
      force_wr_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      ack_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      last_wr_q <= last_wr_d;
      force_wr_q <= force_wr_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_ram_lane_scheduler.sv
// tb_ram_lane_scheduler: directed and randomized checks of ram_lane_scheduler against a RAM image model
module tb_ram_lane_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_ready = 1'b0;
  logic nxt_wr;
  int errs = 0;
  int checks = 0;
  logic [15:0] ram_m [256];
  logic [15:0] mdl [256];
  ram_lane_scheduler_if bus();
  ram_lane_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    case (a)
      8'h3E: return 16'd3;
      8'h40: return 16'd2;
      8'h41: return 16'd1;
      8'h42: return 16'd45;
      default: return 16'(a * 257) ^ 16'h1357;
    endcase
  endfunction

  // three-lane RAM: synchronous read, writes applied lane 0..2 so lane 2 wins
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int a = 0; a < 256; a++) ram_m[a] <= init_val(a);
      ram_ready <= 1'b1;
    end else begin
      if (bus.mem_write)
        for (int i = 0; i < 3; i++) ram_m[bus.mem_address[i*8 +: 8]] <= bus.mem_data_in[i*16 +: 16];
      if (bus.mem_read)
        for (int i = 0; i < 3; i++) bus.mem_data_out[i*16 +: 16] <= ram_m[bus.mem_address[i*8 +: 8]];
    end
  end

  // drives one request set, drops each lane's request when its ack appears, records ack cycle numbers
  task automatic run(input logic [2:0] req, input logic [2:0] we, input logic [23:0] a, input logic [47:0] d,
                     output logic [2:0][3:0] ak, output logic [47:0] rd, output int nrd, output int nwr, output int both);
    logic [2:0] live;
    ak = '0; rd = '0; nrd = 0; nwr = 0; both = 0;
    bus.lane_req = req; bus.lane_we = we; bus.lane_addr = a; bus.lane_wdata = d;
    live = req;
    for (int k = 1; k <= 12 && live != 0; k++) begin
      @(negedge clk);
      nrd += int'(bus.mem_read); nwr += int'(bus.mem_write); both += int'(bus.mem_read & bus.mem_write);
      for (int i = 0; i < 3; i++)
        if (bus.lane_ack[i] && ak[i] == 0) begin
          ak[i] = 4'(k); rd[i*16 +: 16] = bus.lane_rdata[i*16 +: 16]; live[i] = 1'b0;
        end
      bus.lane_req = live;
    end
    bus.lane_req = '0;
    @(negedge clk);
    nrd += int'(bus.mem_read); nwr += int'(bus.mem_write); both += int'(bus.mem_read & bus.mem_write);
  endtask

  task automatic test_reset();
    checks++; if (bus.mem_read !== 1'b0) begin errs++; $display("FAIL reset_mem_read: got %0h want 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errs++; $display("FAIL reset_mem_write: got %0h want 0", bus.mem_write); end
    checks++; if (bus.mem_address !== 24'h0) begin errs++; $display("FAIL reset_mem_address: got %0h want 0", bus.mem_address); end
    checks++; if (bus.mem_data_in !== 48'h0) begin errs++; $display("FAIL reset_mem_data_in: got %0h want 0", bus.mem_data_in); end
    checks++; if (bus.lane_ack !== 3'b0) begin errs++; $display("FAIL reset_lane_ack: got %0h want 0", bus.lane_ack); end
    checks++; if (bus.lane_rdata !== 48'h0) begin errs++; $display("FAIL reset_lane_rdata: got %0h want 0", bus.lane_rdata); end
  endtask

  task automatic test_single_read();
    bus.lane_req = 3'b001; bus.lane_we = 3'b000; bus.lane_addr = 24'h00003E;
    @(negedge clk);
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errs++; $display("FAIL rd1_strobe: got r%0h w%0h want r1 w0", bus.mem_read, bus.mem_write); end
    checks++; if (bus.mem_address !== 24'h3E3E3E) begin errs++; $display("FAIL rd1_addr: got %0h want 3e3e3e", bus.mem_address); end
    @(negedge clk);
    checks++; if (bus.mem_read !== 1'b0 || bus.lane_ack !== 3'b000) begin errs++; $display("FAIL rd1_cycle2: got r%0h ack%0h want r0 ack0", bus.mem_read, bus.lane_ack); end
    @(negedge clk);
    checks++; if (bus.lane_ack !== 3'b001) begin errs++; $display("FAIL rd1_ack: got %0h want 1", bus.lane_ack); end
    checks++; if (bus.lane_rdata[15:0] !== mdl[8'h3E]) begin errs++; $display("FAIL rd1_data: got %0h want %0h", bus.lane_rdata[15:0], mdl[8'h3E]); end
    bus.lane_req = '0;
    @(negedge clk);
  endtask

  task automatic test_batch_read();
    logic [2:0][3:0] ak; logic [47:0] rd; int nrd, nwr, both;
    run(3'b111, 3'b000, 24'h424140, 48'h0, ak, rd, nrd, nwr, both);
    checks++; if (ak !== {4'd3, 4'd3, 4'd3}) begin errs++; $display("FAIL rd3_ack_cycles: got %0h want 333", ak); end
    checks++; if (rd !== {mdl[8'h42], mdl[8'h41], mdl[8'h40]}) begin errs++; $display("FAIL rd3_data: got %0h want %0h%0h%0h", rd, mdl[8'h42], mdl[8'h41], mdl[8'h40]); end
    checks++; if (nrd !== 1 || nwr !== 0) begin errs++; $display("FAIL rd3_strobes: got r%0d w%0d want r1 w0", nrd, nwr); end
  endtask

  task automatic test_single_write();
    int bad = 0;
    bus.lane_req = 3'b010; bus.lane_we = 3'b010; bus.lane_addr = 24'h915207; bus.lane_wdata = 48'hBEEF_1234_0F0F;
    @(negedge clk);
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errs++; $display("FAIL wr1_strobe: got w%0h r%0h want w1 r0", bus.mem_write, bus.mem_read); end
    checks++; if (bus.mem_address !== 24'h525252) begin errs++; $display("FAIL wr1_addr: got %0h want 525252", bus.mem_address); end
    checks++; if (bus.mem_data_in !== 48'h1234_1234_1234) begin errs++; $display("FAIL wr1_data: got %0h want 123412341234", bus.mem_data_in); end
    @(negedge clk);
    checks++; if (bus.lane_ack !== 3'b010) begin errs++; $display("FAIL wr1_ack: got %0h want 2", bus.lane_ack); end
    bus.lane_req = '0;
    @(negedge clk);
    checks++; if (bus.mem_write !== 1'b0) begin errs++; $display("FAIL wr1_one_strobe: got %0h want 0", bus.mem_write); end
    mdl[8'h52] = 16'h1234;
    for (int a = 0; a < 256; a++) if (ram_m[a] !== mdl[a]) bad++;
    checks++; if (bad !== 0) begin errs++; $display("FAIL wr1_memory: got %0d differing words want 0", bad); end
  endtask

  task automatic test_mixed();
    logic [2:0][3:0] ak; logic [47:0] rd; int nrd, nwr, both;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    run(3'b101, 3'b100, 24'h53_10_3F, 48'h0007_0000_0000, ak, rd, nrd, nwr, both);
    checks++; if (ak !== {4'd5, 4'd0, 4'd3}) begin errs++; $display("FAIL mix1_ack_cycles: got %0h want 503", ak); end
    checks++; if (rd[15:0] !== mdl[8'h3F]) begin errs++; $display("FAIL mix1_data: got %0h want %0h", rd[15:0], mdl[8'h3F]); end
    checks++; if (nrd !== 1 || nwr !== 1 || both !== 0) begin errs++; $display("FAIL mix1_strobes: got r%0d w%0d both%0d want 1 1 0", nrd, nwr, both); end
    mdl[8'h53] = 16'd7;
    run(3'b011, 3'b001, 24'h20_3E_54, 48'h0000_0000_0009, ak, rd, nrd, nwr, both);
    checks++; if (ak !== {4'd0, 4'd5, 4'd2}) begin errs++; $display("FAIL mix2_ack_cycles: got %0h want 052", ak); end
    checks++; if (rd[31:16] !== mdl[8'h3E]) begin errs++; $display("FAIL mix2_data: got %0h want %0h", rd[31:16], mdl[8'h3E]); end
    mdl[8'h54] = 16'd9;
  endtask

  task automatic test_collision();
    logic [2:0][3:0] ak; logic [47:0] rd; int nrd, nwr, both, bad;
    bad = 0;
    run(3'b101, 3'b101, 24'h55_10_55, 48'h5555_0000_AAAA, ak, rd, nrd, nwr, both);
`ifdef RAM_SCHED_SERIALIZE_EN
    checks++; if (ak !== {4'd4, 4'd0, 4'd2}) begin errs++; $display("FAIL coll_ack_cycles: got %0h want 402", ak); end
    checks++; if (nwr !== 2) begin errs++; $display("FAIL coll_strobes: got %0d want 2", nwr); end
`else
    checks++; if (ak !== {4'd2, 4'd0, 4'd2}) begin errs++; $display("FAIL coll_ack_cycles: got %0h want 202", ak); end
    checks++; if (nwr !== 1) begin errs++; $display("FAIL coll_strobes: got %0d want 1", nwr); end
`endif
    mdl[8'h55] = 16'h5555;
    checks++; if (ram_m[8'h55] !== 16'h5555) begin errs++; $display("FAIL coll_final: got %0h want 5555", ram_m[8'h55]); end
    for (int a = 0; a < 256; a++) if (ram_m[a] !== mdl[a]) bad++;
    checks++; if (bad !== 0) begin errs++; $display("FAIL coll_memory: got %0d differing words want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int t;
    bus.lane_req = 3'b010; bus.lane_we = 3'b000; bus.lane_addr = 24'h004100;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.lane_ack !== 3'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errs++; $display("FAIL rst_mid_ctrl: got ack%0h r%0h w%0h want 0", bus.lane_ack, bus.mem_read, bus.mem_write); end
    checks++; if (bus.mem_address !== 24'h0 || bus.mem_data_in !== 48'h0 || bus.lane_rdata !== 48'h0) begin errs++; $display("FAIL rst_mid_data: got a%0h d%0h rd%0h want 0", bus.mem_address, bus.mem_data_in, bus.lane_rdata); end
    reset = 1'b0;
    t = 0;
    while (bus.lane_ack == 3'b0 && t < 10) begin @(negedge clk); t++; end
    checks++; if (t !== 3 || bus.lane_ack !== 3'b010) begin errs++; $display("FAIL rst_mid_resample: got cycle %0d ack %0h want cycle 3 ack 2", t, bus.lane_ack); end
    checks++; if (bus.lane_rdata[31:16] !== mdl[8'h41]) begin errs++; $display("FAIL rst_mid_data_after: got %0h want %0h", bus.lane_rdata[31:16], mdl[8'h41]); end
    bus.lane_req = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] req, we; logic [23:0] a; logic [47:0] d, rd; logic [2:0][3:0] ak;
    int nrd, nwr, both, bad, a0, a1, a2, exp_k;
    logic has_r, has_w, wfirst;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    nxt_wr = 1'b0;
    for (int r = 0; r < 40; r++) begin
      req = 3'($urandom_range(1, 7)); we = 3'($urandom);
      a0 = int'($urandom_range(0, 80)); a1 = a0 + 1 + int'($urandom_range(0, 80)); a2 = a1 + 1 + int'($urandom_range(0, 80));
      a = {8'(a2), 8'(a1), 8'(a0)};
      for (int i = 0; i < 3; i++) d[i*16 +: 16] = 16'($urandom);
      has_r = |(req & ~we); has_w = |(req & we);
      wfirst = has_w && (!has_r || nxt_wr);
      if (has_r && has_w) nxt_wr = !wfirst;
      run(req, we, a, d, ak, rd, nrd, nwr, both);
      for (int i = 0; i < 3; i++) begin
        exp_k = !req[i] ? 0 : (we[i] == wfirst) ? (we[i] ? 2 : 3) : 5;
        checks++; if (ak[i] !== 4'(exp_k)) begin errs++; $display("FAIL rnd%0d_ack_lane%0d: got cycle %0d want %0d", r, i, ak[i], exp_k); end
        if (req[i] && !we[i]) begin
          checks++; if (rd[i*16 +: 16] !== mdl[a[i*8 +: 8]]) begin errs++; $display("FAIL rnd%0d_data_lane%0d: got %0h want %0h", r, i, rd[i*16 +: 16], mdl[a[i*8 +: 8]]); end
        end
      end
      checks++; if (nrd !== int'(has_r) || nwr !== int'(has_w) || both !== 0) begin errs++; $display("FAIL rnd%0d_strobes: got r%0d w%0d both%0d want r%0d w%0d both0", r, nrd, nwr, both, has_r, has_w); end
      for (int i = 0; i < 3; i++) if (req[i] && we[i]) mdl[a[i*8 +: 8]] = d[i*16 +: 16];
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (ram_m[x] !== mdl[x]) bad++;
    checks++; if (bad !== 0) begin errs++; $display("FAIL rnd_memory: got %0d differing words want 0", bad); end
  endtask

  initial begin
    bus.lane_req = '0; bus.lane_we = '0; bus.lane_addr = '0; bus.lane_wdata = '0;
    for (int x = 0; x < 256; x++) mdl[x] = init_val(x);
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_single_read();
    test_batch_read();
    test_single_write();
    test_mixed();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ram_lane_scheduler.md
# ram_lane_scheduler

Access scheduler for the shared 3-lane `ram` block: collects independent read/write requests from three requester lanes (processor cores of the 3x3 build), batches compatible requests into single RAM cycles, and returns read data and per-lane acknowledges. Sits between the three core memory interfaces and the one `ram` instance. It guarantees the RAM never sees `read` and `write` together, and that unused RAM lanes never corrupt memory.

## Interface
- `DATA_LEN`, 16, word width per lane (matches `ram`)
- `ADDRESS_LEN`, 8, address width per lane (matches `ram`)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `lane_req`  in  3  per-lane request level; held until matching `lane_ack`
- `lane_we`  in  3  per-lane 1=write, 0=read; sampled with `lane_req`
- `lane_addr`  in  3*ADDRESS_LEN  lane i at bits [i*ADDRESS_LEN +: ADDRESS_LEN]
- `lane_wdata`  in  3*DATA_LEN  lane i at bits [i*DATA_LEN +: DATA_LEN]
- `lane_rdata`  out  3*DATA_LEN  registered read data, valid while `lane_ack[i]`=1
- `lane_ack`  out  3  one-cycle completion pulse per lane
- `mem_read`, `mem_write`  out  1 each  to `ram` `read`/`write`
- `mem_address`  out  3*ADDRESS_LEN  to `ram` `address`
- `mem_data_in`  out  3*DATA_LEN  to `ram` `data_in`
- `mem_data_out`  in  3*DATA_LEN  from `ram` `data_out`

## Operation
- States: IDLE, RD_ISSUE, RD_DONE, WR_ISSUE. All outputs registered.
- IDLE: new lanes = `lane_req` & ~pending & ~`lane_ack`; capture their we/addr/wdata into per-lane registers, set pending bits. Lanes with `lane_ack` high this cycle are never resampled.
- Class select over pending (old + new): only reads -> RD_ISSUE; only writes -> WR_ISSUE; both -> opposite of last served class (`last_wr` flag, reset 0 => reads first). None -> stay IDLE.
- Batch: all pending lanes of the chosen class form the grant mask.
- Unused RAM lanes are filled with the lowest granted lane's address (and data for writes): duplicate same-address/same-data writes are harmless.
- RD_ISSUE: `mem_read`=1 for one cycle -> RD_DONE. RD_DONE: copy `mem_data_out` slice i to `lane_rdata` slice i for granted lanes; pulse their `lane_ack`; clear pending bits; -> IDLE.
- WR_ISSUE: `mem_write`=1 for one cycle; pulse `lane_ack` of granted lanes next cycle; clear pending; -> IDLE.
- Write address collision (two granted write lanes, equal address): see Configuration.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_data_in`=0, `lane_ack`=0, `lane_rdata`=0, pending=0, `last_wr`=0, state IDLE.
- Read: request sampled at edge E0; `mem_read` high E0-E1; `lane_ack`+`lane_rdata` high E2-E3 (3 cycles).
- Write: sampled at E0; `mem_write` high E0-E1; `lane_ack` high E1-E2 (2 cycles).
- Requester drops `lane_req` in the ack cycle; a request still high during ack is ignored, then resampled at the next IDLE if still present.
- Lane requesting while another batch is in flight waits; it is captured at the next IDLE cycle.
- Mixed read+write pending: served back-to-back, alternating; deferred class keeps its pending bits, no starvation (worst case one extra batch).
- Reset mid-operation: all state cleared next edge, no acks issued; a write whose strobe cycle coincides with `reset` still lands in RAM.
- `lane_addr`/`lane_wdata` need only be valid in the sampling cycle.

## Configuration
- `RAM_SCHED_SERIALIZE_EN` defined: colliding write lanes are split; the lowest-indexed lane of each colliding address is granted, the others stay pending for the following WR batch (no intervening read batch). Result: every write observable in lane order, highest lane last.
- Not defined: colliding writes issued in one batch; RAM resolves, lane 2 > lane 1 > lane 0 wins; all lanes acked together.

## Test plan
- Single read lane 0, addr 0x3E on initial RAM image -> `mem_read` one cycle, `lane_ack`=001 at cycle 3, `lane_rdata[15:0]`=3.
- Reads lanes 0/1/2 at 0x40/0x41/0x42 same cycle -> one RAM read, `lane_ack`=111 together, data 2/1/45.
- Lane 1 write 0x52<=0x1234, others idle -> one `mem_write`, all three `mem_address` slices 0x52, ack at cycle 2; read-back 0x1234; no other address changed.
- Lane 0 read 0x3F + lane 2 write 0x53<=7 same cycle, after reset -> read batch first (ack 001), then write batch (ack 100); next mixed pair served write first.
- Lanes 0 and 2 write 0x55 with 0xAAAA/0x5555 -> with macro: two write cycles, final 0x5555, acks 001 then 100; without: one cycle, final 0x5555, ack 101.
- `reset` asserted in RD_DONE cycle -> no `lane_ack`, all outputs 0 next cycle; held `lane_req` resampled after release.
